fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage pipelined CPU. Holds the PC and drives the synchronous instruction
//  memory, which has 1-cycle read latency. Loads the IF/ID pipeline register that feeds decode
//  (reg file, imm gen, control unit).
//  Handles PC redirect from EX/MEM (branch/jump) and stall from hazard detection. A 1-entry skid
//  buffer ensures no fetched word is lost during a stall.
// PARAMETERS
//  PC_W      32  PC / instruction width (word-addressed, PC advances by 1)
//  IMEM_AW   8   instruction memory address width (low bits of PC)
//  RESET_PC  0   PC value loaded at reset
// PORTS
//  clk            in   1        clock, all state on rising edge
//  rst            in   1        synchronous active-high reset
//  redirect       in   1        take redirect_pc (PCSel from EX/MEM); squashes younger fetches
//  redirect_pc    in   PC_W     branch/jump target
//  stall          in   1        hold IF/ID and PC (load-use hazard)
//  imem_req       out  1        read strobe to instruction memory
//  imem_addr      out  IMEM_AW  read address = pc_f[IMEM_AW-1:0]
//  imem_rdata     in   32       instruction, valid the cycle after imem_req
//  ifid_valid     out  1        IF/ID holds a real instruction (0 = bubble)
//  ifid_pc        out  PC_W     PC of ifid_inst
//  ifid_pc_plus1  out  PC_W     ifid_pc+1, registered (PCtoReg link value)
//  ifid_inst      out  32       instruction ([31:26] op, [25:20] rs, [19:14] rt, [13:8] rd)
//  fetch_count    out  32       count of instructions loaded into IF/ID (wraps)
// BEHAVIOUR
//  State: pc_f (next address to issue), pend_v/pend_pc (request issued last cycle),
//   skid_v/skid_pc/skid_inst, IF/ID regs.
//  Reset: pc_f=RESET_PC. pend_v, skid_v and ifid_valid =0. ifid_pc, ifid_pc_plus1, ifid_inst,
//   fetch_count =0. imem_req=0 while rst is high.
//  imem_req = !rst && !redirect && !stall (combinational). imem_addr is always pc_f low bits.
//  Per-edge priority: rst > redirect > stall > normal.
//  redirect: pc_f<=redirect_pc. pend_v, skid_v, ifid_valid <=0 (squash). Other IF/ID fields hold.
//   Applies even if stall is also high.
//  stall (no redirect): pc_f and IF/ID hold.
//   If pend_v: skid<={pend_pc, imem_rdata}, skid_v<=1. Then pend_v<=0.
//  normal (stall=0, redirect=0): request issued, so pend_v<=1, pend_pc<=pc_f, pc_f<=pc_f+1.
//   IF/ID source, in priority order:
//    - skid_v: load from skid, skid_v<=0.
//    - else pend_v: load {pend_pc, imem_rdata}.
//    - else ifid_valid<=0.
//   On every load: ifid_valid<=1, ifid_pc_plus1<=source pc+1, fetch_count<=fetch_count+1.
//  Invariant: skid_v && pend_v never both 1 (assert in bench).
//  Latency: first ifid_valid=1 (pc=RESET_PC) is at the 2nd rising edge after rst falls.
//   After a redirect edge, the first valid target instruction is at the 2nd following edge.
//   Redirect penalty is 2 bubbles.
//  Wrap: pc_f wraps modulo 2^PC_W. imem_addr wraps at 2^IMEM_AW. fetch_count wraps 2^32-1 -> 0.
//  Unstall after a skid capture: the skid word enters IF/ID on the first non-stalled edge.
//   A new fetch is issued in the same cycle, so there is no gap.
//  Reset mid-stall or mid-redirect discards all in-flight and skid state.
// TESTING
//  1 Reset, imem[k]=k+100, no stall/redirect -> ifid_valid from edge 2; ifid_pc=0,1,2...
//    ifid_inst=100,101,...; fetch_count increments each edge.
//  2 stall high 3 cycles mid-stream (ifid_pc=5) -> IF/ID holds pc 5; skid holds pc 6.
//    After release: pc 6 then 7, no gap/dup; imem_req=0 during stall.
//  3 redirect=1, redirect_pc=0x40 while ifid_pc=9 -> next edge ifid_valid=0; pc 10/11 never appear.
//    Then ifid_pc=0x40 two edges after redirect.
//  4 redirect and stall together with skid full -> skid squashed.
//    ifid_pc=0x20 valid two edges later (redirect_pc=0x20).
//  5 RESET_PC=0xFE, IMEM_AW=8 -> imem_addr 0xFE,0xFF,0x00; ifid_pc 0xFE,0xFF,0x100.
//    ifid_pc_plus1 = ifid_pc+1.
//  6 rst asserted during stall with skid_v=1 -> next edge all valids 0, fetch_count=0.
//    Restart from RESET_PC identical to test 1.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   IF stage of the 5-stage pipeline. Owns the fetch PC, drives the synchronous
//   instruction memory (1-cycle read latency) and loads the IF/ID register
//   consumed by decode. Handles redirects from EX/MEM and stalls from hazard
//   detection. A 1-entry skid buffer catches the word that returns from memory
//   during the first stalled cycle, so no fetched instruction is ever lost.
//
// Ports
//   clk, rst        clock / synchronous active-high reset
//   redirect        take redirect_pc, squash every younger fetch
//   redirect_pc     branch / jump target
//   stall           hold PC and IF/ID
//   imem_req        read strobe to instruction memory (combinational)
//   imem_addr       read address, low IMEM_AW bits of pc_f
//   imem_rdata      instruction data, valid the cycle after imem_req
//   ifid_valid      IF/ID holds a real instruction (0 = bubble)
//   ifid_pc         PC of ifid_inst
//   ifid_pc_plus1   ifid_pc + 1 (link value)
//   ifid_inst       fetched instruction
//   fetch_count     instructions loaded into IF/ID (wraps)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int              PC_W     = 32,
    parameter int              IMEM_AW  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               stall,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               ifid_valid,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [PC_W-1:0]    ifid_pc_plus1,
    output logic [31:0]        ifid_inst,
    output logic [31:0]        fetch_count
);

    // fetch PC and the request that is currently in flight in the memory
    logic [PC_W-1:0] pc_f_q, pc_f_d;
    logic            pend_v_q, pend_v_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;

    // skid buffer: parks the word that returns while IF/ID is stalled
    logic            skid_v_q, skid_v_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_inst_q, skid_inst_d;

    // IF/ID pipeline register
    logic            ifid_valid_q, ifid_valid_d;
    logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [PC_W-1:0] ifid_pc_plus1_q, ifid_pc_plus1_d;
    logic [31:0]     ifid_inst_q, ifid_inst_d;
    logic [31:0]     fetch_count_q, fetch_count_d;

    // IF/ID load source selection
    logic            ld;
    logic [PC_W-1:0] src_pc;
    logic [31:0]     src_inst;

    // A request is only issued on a cycle that will actually advance the PC;
    // redirect and stall cycles never start a memory read.
    assign imem_req  = !rst && !redirect && !stall;
    assign imem_addr = pc_f_q[IMEM_AW-1:0];

    always_comb begin
        pc_f_d          = pc_f_q;
        pend_v_d        = pend_v_q;
        pend_pc_d       = pend_pc_q;
        skid_v_d        = skid_v_q;
        skid_pc_d       = skid_pc_q;
        skid_inst_d     = skid_inst_q;
        ifid_valid_d    = ifid_valid_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus1_d = ifid_pc_plus1_q;
        ifid_inst_d     = ifid_inst_q;
        fetch_count_d   = fetch_count_q;
        ld              = 1'b0;
        src_pc          = pend_pc_q;
        src_inst        = imem_rdata;

        if (redirect) begin
            // squash everything younger than the redirecting instruction,
            // regardless of stall; IF/ID payload is left as-is under valid=0
            pc_f_d       = redirect_pc;
            pend_v_d     = 1'b0;
            skid_v_d     = 1'b0;
            ifid_valid_d = 1'b0;
        end else if (stall) begin
            // the in-flight word shows up now and IF/ID cannot take it
            if (pend_v_q) begin
                skid_v_d    = 1'b1;
                skid_pc_d   = pend_pc_q;
                skid_inst_d = imem_rdata;
            end
            pend_v_d = 1'b0;
        end else begin
            pend_v_d  = 1'b1;
            pend_pc_d = pc_f_q;
            pc_f_d    = pc_f_q + PC_W'(1);

            // skid is older than anything in flight, so it drains first
            if (skid_v_q) begin
                ld       = 1'b1;
                src_pc   = skid_pc_q;
                src_inst = skid_inst_q;
                skid_v_d = 1'b0;
            end else if (pend_v_q) begin
                ld       = 1'b1;
                src_pc   = pend_pc_q;
                src_inst = imem_rdata;
            end

            if (ld) begin
                ifid_valid_d    = 1'b1;
                ifid_pc_d       = src_pc;
                ifid_pc_plus1_d = src_pc + PC_W'(1);
                ifid_inst_d     = src_inst;
                fetch_count_d   = fetch_count_q + 32'd1;
            end else begin
                ifid_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q          <= RESET_PC;
            pend_v_q        <= 1'b0;
            pend_pc_q       <= '0;
            skid_v_q        <= 1'b0;
            skid_pc_q       <= '0;
            skid_inst_q     <= '0;
            ifid_valid_q    <= 1'b0;
            ifid_pc_q       <= '0;
            ifid_pc_plus1_q <= '0;
            ifid_inst_q     <= '0;
            fetch_count_q   <= '0;
        end else begin
            pc_f_q          <= pc_f_d;
            pend_v_q        <= pend_v_d;
            pend_pc_q       <= pend_pc_d;
            skid_v_q        <= skid_v_d;
            skid_pc_q       <= skid_pc_d;
            skid_inst_q     <= skid_inst_d;
            ifid_valid_q    <= ifid_valid_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus1_q <= ifid_pc_plus1_d;
            ifid_inst_q     <= ifid_inst_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    assign ifid_valid    = ifid_valid_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus1 = ifid_pc_plus1_q;
    assign ifid_inst     = ifid_inst_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Scoreboard bench for fetch_stage. Every issued fetch (normal cycle) pushes
//   its PC; redirect and reset flush the queue. After each edge that should
//   load IF/ID, the oldest PC is popped and compared against IF/ID. A second
//   instance with RESET_PC=0xFE covers address / PC wrap.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst, redirect, stall;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_pc_plus1, ifid_inst, fetch_count;

    logic        rst2, redirect2, stall2;
    logic [31:0] redirect_pc2;
    logic        imem_req2;
    logic [7:0]  imem_addr2;
    logic [31:0] imem_rdata2;
    logic        ifid_valid2;
    logic [31:0] ifid_pc2, ifid_pc_plus12, ifid_inst2, fetch_count2;

    int n_cmp = 0;
    int n_err = 0;

    fetch_stage #(.PC_W(32), .IMEM_AW(8), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
        .ifid_pc_plus1(ifid_pc_plus1), .ifid_inst(ifid_inst),
        .fetch_count(fetch_count)
    );

    fetch_stage #(.PC_W(32), .IMEM_AW(8), .RESET_PC(32'hFE)) u_dut5 (
        .clk(clk), .rst(rst2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .stall(stall2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .ifid_valid(ifid_valid2), .ifid_pc(ifid_pc2),
        .ifid_pc_plus1(ifid_pc_plus12), .ifid_inst(ifid_inst2),
        .fetch_count(fetch_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory contents: imem[k] = k + 100
    function automatic logic [31:0] minst(input logic [31:0] p);
        return {24'd0, p[7:0]} + 32'd100;
    endfunction

    always @(posedge clk) if (imem_req)  imem_rdata  <= minst({24'd0, imem_addr});
    always @(posedge clk) if (imem_req2) imem_rdata2 <= minst({24'd0, imem_addr2});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // scoreboard / expected IF/ID state
    logic [31:0] sb[$];
    logic [31:0] pc_m;
    bit          pc_known = 0;
    logic        e_v;
    logic [31:0] e_pc, e_pp1, e_inst, e_cnt;

    // one clock of stimulus; called right after an active edge
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic st);
        bit          ld;
        logic [31:0] h;
        rst = r; redirect = rd; redirect_pc = rpc; stall = st;
        #1;
        chk("req", 32'(imem_req), 32'(!r && !rd && !st));
        if (pc_known) chk("addr", 32'(imem_addr), {24'd0, pc_m[7:0]});
        ld = 0;
        if (r) begin
            sb.delete(); pc_m = 32'h0; pc_known = 1;
            e_v = 0; e_pc = 0; e_pp1 = 0; e_inst = 0; e_cnt = 0;
        end else if (rd) begin
            sb.delete(); pc_m = rpc; e_v = 0;
        end else if (!st) begin
            sb.push_back(pc_m);
            pc_m = pc_m + 32'd1;
            // something older than the fetch just issued will load now
            ld = (sb.size() > 1);
            if (!ld) e_v = 0;
        end
        @(posedge clk); #1;
        if (ld) begin
            h = sb.pop_front();
            e_v = 1; e_pc = h; e_pp1 = h + 32'd1; e_inst = minst(h); e_cnt = e_cnt + 32'd1;
        end
        chk("valid", 32'(ifid_valid), 32'(e_v));
        chk("pc",    ifid_pc,       e_pc);
        chk("pc+1",  ifid_pc_plus1, e_pp1);
        chk("inst",  ifid_inst,     e_inst);
        chk("count", fetch_count,   e_cnt);
        chk("skid_pend_excl", 32'(u_dut.skid_v_q & u_dut.pend_v_q), 32'd0);
    endtask

    initial begin
        int r;
        rst = 1; redirect = 0; redirect_pc = 0; stall = 0;
        rst2 = 1; redirect2 = 0; redirect_pc2 = 0; stall2 = 0;

        // 1: reset and straight-line fetch; pc 0..5 loaded
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
        chk("t2_pc5", ifid_pc, 32'd5);

        // 2: 3-cycle stall with pc 5 in IF/ID, then release
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        chk("t2_skid", 32'(u_dut.skid_v_q), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("t3_pc9", ifid_pc, 32'd9);

        // 3: redirect to 0x40
        step(0, 1, 32'h40, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // 4: fill skid, then redirect together with stall
        step(0, 0, 0, 1);
        step(0, 1, 32'h20, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // PC wrap at 2^32
        step(0, 1, 32'hFFFF_FFFF, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // random mix of stalls and redirects
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 99);
            if (r < 25)      step(0, 0, 0, 1);
            else if (r < 33) step(0, 1, $urandom_range(0, 255), 0);
            else             step(0, 0, 0, 0);
        end

        // 6: reset while stalled with the skid full, then restart
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("t6_skid", 32'(u_dut.skid_v_q), 32'd1);
        step(1, 0, 0, 1);
        chk("t6_skid0", 32'(u_dut.skid_v_q), 32'd0);
        chk("t6_pend0", 32'(u_dut.pend_v_q), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("t6_pc3", ifid_pc, 32'd3);

        // 5: RESET_PC=0xFE instance, address and PC wrap
        rst = 1;
        rst2 = 0;
        #1;
        chk("w_addr0", 32'(imem_addr2), 32'hFE);
        @(posedge clk); #1;
        chk("w_addr1", 32'(imem_addr2), 32'hFF);
        chk("w_v1",    32'(ifid_valid2), 32'd0);
        @(posedge clk); #1;
        chk("w_addr2", 32'(imem_addr2), 32'h00);
        chk("w_v2",    32'(ifid_valid2), 32'd1);
        chk("w_pc2",   ifid_pc2, 32'hFE);
        chk("w_pp2",   ifid_pc_plus12, 32'hFF);
        chk("w_in2",   ifid_inst2, 32'd354);
        @(posedge clk); #1;
        chk("w_pc3",   ifid_pc2, 32'hFF);
        chk("w_pp3",   ifid_pc_plus12, 32'h100);
        chk("w_in3",   ifid_inst2, 32'd355);
        @(posedge clk); #1;
        chk("w_pc4",   ifid_pc2, 32'h100);
        chk("w_pp4",   ifid_pc_plus12, 32'h101);
        chk("w_in4",   ifid_inst2, 32'd100);
        chk("w_cnt4",  fetch_count2, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
